mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencing controller that shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch requester (IF stage) and data requester (MEM stage). It serializes requests and runs each transaction through a small FSM. It returns read data with a one-cycle ready pulse and produces the pipeline hold signal used to freeze PC, IF/ID and later stage registers while a requester waits. It sits between the pipeline datapath's memory ports and the external memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles; mem_rdata is valid in the MEM_LAT-th cycle of mem_en assertion; legal range ≥1

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_cancel  in  1  branch flush: discard in-flight fetch result
- if_rdata  out  DATA_W  fetched instruction
- if_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_ready  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- hold  out  1  pipeline stall: (if_req & ~if_ready) | (d_req & ~d_ready), combinational

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE with no request: stays in IDLE.
- IDLE with a request: grants, latches owner, address, we and wdata, loads counter = MEM_LAT-1, then moves to BUSY.
- Grant rule:
  - Only one requester asserted: grant it.
  - Both asserted: grant the one not served last (last_owner register). last_owner resets to DATA, so IF wins the first conflict.
  - last_owner updates at grant.
- BUSY: mem_en=1. mem_we=1 only for a data store. mem_addr and mem_wdata are driven from the latched values.
  - Counter decrements each cycle.
  - When counter==0: capture mem_rdata into the owner's rdata register (loads and fetches only), then go to DONE.
- DONE: assert the owner's ready for exactly one cycle, then go unconditionally to IDLE. The next request is sampled in IDLE, never in DONE.
- Stores: d_ready pulses; d_rdata is unchanged.
- Cancel: if if_cancel is sampled high in any BUSY cycle of an IF-owned transaction, set a cancel flag.
  - The memory access still completes.
  - if_rdata is not updated.
  - if_ready is suppressed in DONE.
  - The flag clears on DONE.
  - if_cancel has no effect in IDLE or DONE, or on data-owned transactions.
- Request inputs change during BUSY: no effect, because the latched values are used.
- rdata registers hold their value until the next capture for the same owner.

## Timing
- Reset (sync):
  - state=IDLE, counter=0, last_owner=DATA, cancel flag=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
  - All take effect at the reset edge.
  - Reset during BUSY aborts the transaction, and mem_en is low in the following cycle.
- Transaction with request seen in IDLE at cycle T:
  - BUSY during cycles T+1 … T+MEM_LAT (mem_en high for MEM_LAT cycles).
  - DONE at T+MEM_LAT+1, with ready high and rdata valid.
  - IDLE at T+MEM_LAT+2.
  - Per-transaction occupancy is MEM_LAT+2 cycles.
- Back-to-back: a requester may present a new request in the cycle after ready; it is granted at that IDLE cycle.
- mem_en, mem_we, mem_addr and mem_wdata are registered outputs.
- ready outputs are registered.
- hold is combinational from the request inputs and the registered ready outputs.
- Counter width is $clog2(MEM_LAT+1). For MEM_LAT=1, BUSY lasts exactly one cycle.

## Test plan
- Single fetch, MEM_LAT=2, memory[0x40]=0x8C220004, if_req at T → mem_en high at T+1 and T+2, if_ready pulse at T+3, if_rdata=0x8C220004, hold high T…T+2 and low at T+3.
- Conflict: if_req and d_req (load from 0x100, value 0x55) both high from reset release → IF is served first (if_ready at T+3), data is granted at the following IDLE, d_ready at T+7 with d_rdata=0x55. A second conflict grants IF again only after data was served.
- Store: d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF → mem_we=1 for exactly MEM_LAT cycles, d_ready pulse, d_rdata unchanged, memory[0x20]=0xDEADBEEF.
- Cancel: fetch granted, if_cancel pulsed in the first BUSY cycle → no if_ready, if_rdata keeps its old value, FSM back in IDLE MEM_LAT+2 cycles after grant; the next fetch completes normally.
- Reset mid-BUSY: assert reset in the second BUSY cycle → next cycle mem_en=0, all outputs at reset values, no ready pulse ever issued for the aborted request.
- MEM_LAT=1 and MEM_LAT=4 builds: fetch ready arrives exactly MEM_LAT+1 cycles after the request cycle, and mem_en is high for exactly MEM_LAT cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the instruction
//   fetch requester and the data requester. Requests are serialized and each
//   one runs IDLE -> BUSY -> DONE. Read data comes back with a one-cycle
//   ready pulse, and hold freezes the pipeline while a requester waits.
//
// Ports
//   clock, reset          sole clock; synchronous active-high reset
//   if_req/if_addr        fetch request (held until if_ready) and address
//   if_cancel             branch flush: drop the in-flight fetch result
//   if_rdata/if_ready     fetched word and its completion pulse
//   d_req/d_we/d_addr     data request (held until d_ready), store flag, address
//   d_wdata               store data
//   d_rdata/d_ready       load data and its completion pulse
//   mem_en/mem_we         memory enable / write enable (registered)
//   mem_addr/mem_wdata    memory address / write data (registered)
//   mem_rdata             memory read data, valid in the MEM_LAT-th enable cycle
//   hold                  pipeline stall, combinational
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no transaction; sample requests and grant one
// ST_BUSY | memory enabled with latched address; counter runs down
// ST_DONE | one-cycle ready pulse for the owner, then back to idle

module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_cancel,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              hold
);

   localparam int               CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
   typedef enum logic {OWN_IF, OWN_DATA} owner_t;

   state_t           state;
   owner_t           owner;
   owner_t           last_owner;
   logic [CNT_W-1:0] cnt;
   logic             cancel_flag;
   logic             grant_data;

   // On a conflict, serve whichever side was not served last.
   always_comb begin
      grant_data = 1'b0;
      if (d_req && !if_req)
         grant_data = 1'b1;
      else if (d_req && if_req)
         grant_data = (last_owner == OWN_IF);
   end

   assign hold = (if_req & ~if_ready) | (d_req & ~d_ready);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         owner       <= OWN_IF;
         last_owner  <= OWN_DATA;
         cnt         <= '0;
         cancel_flag <= 1'b0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         if_ready    <= 1'b0;
         d_ready     <= 1'b0;
         if_rdata    <= '0;
         d_rdata     <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (if_req || d_req) begin
                  state      <= ST_BUSY;
                  owner      <= grant_data ? OWN_DATA : OWN_IF;
                  last_owner <= grant_data ? OWN_DATA : OWN_IF;
                  cnt        <= CNT_LOAD;
                  mem_en     <= 1'b1;
                  mem_we     <= grant_data & d_we;
                  mem_addr   <= grant_data ? d_addr : if_addr;
                  mem_wdata  <= d_wdata;
               end
            end
            ST_BUSY: begin
               if (owner == OWN_IF && if_cancel)
                  cancel_flag <= 1'b1;
               if (cnt == '0) begin
                  state  <= ST_DONE;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  if (owner == OWN_DATA) begin
                     d_ready <= 1'b1;
                     if (!mem_we)
                        d_rdata <= mem_rdata;
                  end else if (!(cancel_flag || if_cancel)) begin
                     // a cancel seen in the final BUSY cycle still counts
                     if_ready <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               state       <= ST_IDLE;
               if_ready    <= 1'b0;
               d_ready     <= 1'b0;
               cancel_flag <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance at MEM_LAT=2 with a
// latency-accurate memory model, plus MEM_LAT=1 and MEM_LAT=4 instances
// exercised with a single fetch each.

module tb_mem_port_arbiter;

   logic        clock;
   logic        reset;

   logic        if_req, if_cancel, if_ready, d_req, d_we, d_ready;
   logic        mem_en, mem_we, hold;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        l1_req, l1_ready, l1_d_ready, l1_en, l1_we, l1_hold;
   logic [31:0] l1_rdata, l1_d_rdata, l1_addr_o, l1_wdata_o, l1_mem_rdata;
   logic        l4_req, l4_ready, l4_d_ready, l4_en, l4_we, l4_hold;
   logic [31:0] l4_rdata, l4_d_rdata, l4_addr_o, l4_wdata_o, l4_mem_rdata;
   logic [31:0] l_addr;

   int n_cmp = 0;
   int n_bad = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
      .if_rdata(if_rdata), .if_ready(if_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hold(hold)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
      .clock(clock), .reset(reset),
      .if_req(l1_req), .if_addr(l_addr), .if_cancel(1'b0),
      .if_rdata(l1_rdata), .if_ready(l1_ready),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_rdata(l1_d_rdata), .d_ready(l1_d_ready),
      .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_addr_o),
      .mem_wdata(l1_wdata_o), .mem_rdata(l1_mem_rdata), .hold(l1_hold)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut_l4 (
      .clock(clock), .reset(reset),
      .if_req(l4_req), .if_addr(l_addr), .if_cancel(1'b0),
      .if_rdata(l4_rdata), .if_ready(l4_ready),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_rdata(l4_d_rdata), .d_ready(l4_d_ready),
      .mem_en(l4_en), .mem_we(l4_we), .mem_addr(l4_addr_o),
      .mem_wdata(l4_wdata_o), .mem_rdata(l4_mem_rdata), .hold(l4_hold)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Main memory: 256 words, data valid only in the 2nd enable cycle.
   logic [31:0] mem [0:255];
   logic [2:0]  en_cnt = 3'd0;
   logic        loaded = 1'b0;
   always @(posedge clock) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[16] <= 32'h8C22_0004;   // 0x40
         mem[17] <= 32'h1111_1111;   // 0x44
         mem[18] <= 32'h2222_2222;   // 0x48
         mem[64] <= 32'h0000_0055;   // 0x100
         loaded  <= 1'b1;
      end else if (mem_en && mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
      en_cnt <= mem_en ? en_cnt + 3'd1 : 3'd0;
   end
   assign mem_rdata = (mem_en && en_cnt == 3'd1) ? mem[mem_addr[9:2]] : 32'hBAD0_BAD0;

   // Latency-variant memories return 0x1000_0000 | address in the last enable cycle.
   logic [2:0] l1_cnt = 3'd0;
   logic [2:0] l4_cnt = 3'd0;
   always @(posedge clock) begin
      l1_cnt <= l1_en ? l1_cnt + 3'd1 : 3'd0;
      l4_cnt <= l4_en ? l4_cnt + 3'd1 : 3'd0;
   end
   assign l1_mem_rdata = (l1_en && l1_cnt == 3'd0) ? (32'h1000_0000 | l1_addr_o) : 32'hBAD0_BAD0;
   assign l4_mem_rdata = (l4_en && l4_cnt == 3'd3) ? (32'h1000_0000 | l4_addr_o) : 32'hBAD0_BAD0;

   task automatic nxt();
      @(negedge clock);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_cancel = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      l1_req = 1'b0; l4_req = 1'b0; l_addr = 32'h0;

      // reset state
      nxt(); nxt();
      chk1 ("rst_mem_en",    mem_en,    1'b0);
      chk1 ("rst_mem_we",    mem_we,    1'b0);
      chk32("rst_mem_addr",  mem_addr,  32'h0);
      chk32("rst_mem_wdata", mem_wdata, 32'h0);
      chk1 ("rst_if_ready",  if_ready,  1'b0);
      chk1 ("rst_d_ready",   d_ready,   1'b0);
      chk32("rst_if_rdata",  if_rdata,  32'h0);
      chk32("rst_d_rdata",   d_rdata,   32'h0);
      chk1 ("rst_hold",      hold,      1'b0);
      reset = 1'b0;

      // single fetch from 0x40
      nxt(); if_req = 1'b1; if_addr = 32'h40; #1;
      chk1 ("f_hold_t0",   hold,   1'b1);
      chk1 ("f_en_t0",     mem_en, 1'b0);
      nxt();
      chk1 ("f_en_t1",     mem_en,   1'b1);
      chk32("f_addr_t1",   mem_addr, 32'h40);
      chk1 ("f_we_t1",     mem_we,   1'b0);
      chk1 ("f_rdy_t1",    if_ready, 1'b0);
      chk1 ("f_hold_t1",   hold,     1'b1);
      nxt();
      chk1 ("f_en_t2",     mem_en, 1'b1);
      chk1 ("f_hold_t2",   hold,   1'b1);
      nxt();
      chk1 ("f_rdy_t3",    if_ready, 1'b1);
      chk32("f_rdata_t3",  if_rdata, 32'h8C22_0004);
      chk1 ("f_en_t3",     mem_en,   1'b0);
      chk1 ("f_hold_t3",   hold,     1'b0);
      if_req = 1'b0;
      nxt();
      chk1 ("f_rdy_t4",    if_ready, 1'b0);

      // store 0xDEADBEEF to 0x20
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
      nxt();
      chk1 ("s_en_t1",     mem_en,    1'b1);
      chk1 ("s_we_t1",     mem_we,    1'b1);
      chk32("s_addr_t1",   mem_addr,  32'h20);
      chk32("s_wdata_t1",  mem_wdata, 32'hDEAD_BEEF);
      nxt();
      chk1 ("s_we_t2",     mem_we, 1'b1);
      nxt();
      chk1 ("s_rdy_t3",    d_ready, 1'b1);
      chk1 ("s_we_t3",     mem_we,  1'b0);
      chk32("s_drdata_t3", d_rdata, 32'h0);
      chk32("s_ifrdata_t3", if_rdata, 32'h8C22_0004);
      chk1 ("s_hold_t3",   hold,    1'b0);
      d_req = 1'b0; d_we = 1'b0;
      nxt();
      chk1 ("s_rdy_t4",    d_ready, 1'b0);
      chk32("s_mem_word",  mem[8],  32'hDEAD_BEEF);

      // fetch 0x44 cancelled in its first busy cycle, then fetch 0x48
      if_req = 1'b1; if_addr = 32'h44;
      nxt();
      chk32("c_addr_t1",   mem_addr, 32'h44);
      if_cancel = 1'b1;
      nxt();
      if_cancel = 1'b0;
      chk1 ("c_en_t2",     mem_en, 1'b1);
      nxt();
      chk1 ("c_rdy_t3",    if_ready, 1'b0);
      chk1 ("c_en_t3",     mem_en,   1'b0);
      chk32("c_rdata_t3",  if_rdata, 32'h8C22_0004);
      chk1 ("c_hold_t3",   hold,     1'b1);
      if_addr = 32'h48;
      nxt();
      chk1 ("c_en_t4",     mem_en, 1'b0);
      nxt();
      chk1 ("c_en_t5",     mem_en,   1'b1);
      chk32("c_addr_t5",   mem_addr, 32'h48);
      nxt(); nxt();
      chk1 ("c_rdy_t7",    if_ready, 1'b1);
      chk32("c_rdata_t7",  if_rdata, 32'h2222_2222);
      if_req = 1'b0;
      nxt();

      // fetch aborted by reset in its second busy cycle
      if_req = 1'b1; if_addr = 32'h48;
      nxt();
      chk1 ("r_en_t1",     mem_en, 1'b1);
      nxt();
      reset = 1'b1;
      nxt();
      chk1 ("r_en_t3",     mem_en,    1'b0);
      chk32("r_addr_t3",   mem_addr,  32'h0);
      chk32("r_wdata_t3",  mem_wdata, 32'h0);
      chk1 ("r_rdy_t3",    if_ready,  1'b0);
      chk32("r_rdata_t3",  if_rdata,  32'h0);
      chk32("r_drdata_t3", d_rdata,   32'h0);
      if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;

      // conflict from reset release: IF first, then data, then IF again
      nxt();
      reset = 1'b0; #1;
      chk1 ("r_rdy_t4",    if_ready, 1'b0);
      chk1 ("x_hold_t0",   hold,     1'b1);
      nxt();
      chk32("x_addr_t1",   mem_addr, 32'h40);
      chk1 ("x_we_t1",     mem_we,   1'b0);
      nxt(); nxt();
      chk1 ("x_ifrdy_t3",  if_ready, 1'b1);
      chk32("x_ifrd_t3",   if_rdata, 32'h8C22_0004);
      chk1 ("x_drdy_t3",   d_ready,  1'b0);
      chk1 ("x_hold_t3",   hold,     1'b1);
      if_addr = 32'h44;
      nxt();
      chk1 ("x_ifrdy_t4",  if_ready, 1'b0);
      nxt();
      chk32("x_addr_t5",   mem_addr, 32'h100);
      chk1 ("x_en_t5",     mem_en,   1'b1);
      nxt(); nxt();
      chk1 ("x_drdy_t7",   d_ready,  1'b1);
      chk32("x_drd_t7",    d_rdata,  32'h55);
      chk1 ("x_ifrdy_t7",  if_ready, 1'b0);
      chk1 ("x_hold_t7",   hold,     1'b1);
      d_addr = 32'h20;
      nxt();
      chk1 ("x_drdy_t8",   d_ready, 1'b0);
      nxt();
      chk32("x_addr_t9",   mem_addr, 32'h44);
      nxt(); nxt();
      chk1 ("x_ifrdy_t11", if_ready, 1'b1);
      chk32("x_ifrd_t11",  if_rdata, 32'h1111_1111);
      chk1 ("x_hold_t11",  hold,     1'b1);
      if_req = 1'b0;
      nxt(); nxt();
      chk32("x_addr_t13",  mem_addr, 32'h20);
      nxt(); nxt();
      chk1 ("x_drdy_t15",  d_ready, 1'b1);
      chk32("x_drd_t15",   d_rdata, 32'hDEAD_BEEF);
      chk1 ("x_hold_t15",  hold,    1'b0);
      d_req = 1'b0;
      nxt();

      // MEM_LAT=1 and MEM_LAT=4 single fetches launched together
      l1_req = 1'b1; l4_req = 1'b1; l_addr = 32'h80;
      for (int k = 1; k <= 6; k++) begin
         nxt();
         chk1("l1_en",    l1_en,      (k == 1));
         chk1("l1_ready", l1_ready,   (k == 2));
         chk1("l1_d_rdy", l1_d_ready, 1'b0);
         chk1("l1_we",    l1_we,      1'b0);
         chk1("l4_en",    l4_en,      (k >= 1 && k <= 4));
         chk1("l4_ready", l4_ready,   (k == 5));
         chk1("l4_d_rdy", l4_d_ready, 1'b0);
         chk1("l4_we",    l4_we,      1'b0);
         if (k == 2) begin
            chk32("l1_rdata", l1_rdata, 32'h1000_0080);
            chk1 ("l1_hold",  l1_hold,  1'b0);
            l1_req = 1'b0;
         end
         if (k == 5) begin
            chk32("l4_rdata", l4_rdata, 32'h1000_0080);
            chk1 ("l4_hold",  l4_hold,  1'b0);
            l4_req = 1'b0;
         end
      end
      chk32("l1_d_rdata", l1_d_rdata, 32'h0);
      chk32("l4_d_rdata", l4_d_rdata, 32'h0);
      chk32("l1_wdata",   l1_wdata_o, 32'h0);
      chk32("l4_wdata",   l4_wdata_o, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
